// File: rtl/mlp_feature_sequencer.sv
// Sensor-stream front end for the combinational quantized-MLP core: quantizes and packs samples,
// waits a settle time, then returns the class index on a valid/ready port. Option: LAST_CHECK_EN.
`timescale 1ns/1ps
module mlp_feature_sequencer #(
    parameter int unsigned N_FEAT     = 8,
    parameter int unsigned IN_W       = 8,
    parameter int unsigned FEAT_W     = 4,
    parameter int unsigned CLASS_W    = 2,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [IN_W-1:0]            s_data_i,
    input  logic                       s_last_i,
    output logic [N_FEAT*FEAT_W-1:0]   mlp_inp_o,
    input  logic [CLASS_W-1:0]         mlp_out_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [CLASS_W-1:0]         m_class_o,
    output logic                       m_err_o
);

    localparam int unsigned CNT_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int unsigned SCNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int unsigned SHIFT  = IN_W - FEAT_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);

    typedef enum logic [1:0] {StLoad, StSettle, StOut} state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SCNT_W-1:0]          scnt_q, scnt_d;
    logic [N_FEAT*FEAT_W-1:0]   inp_q, inp_d;
    logic                       m_valid_q, m_valid_d;
    logic [CLASS_W-1:0]         m_class_q, m_class_d;
    logic [FEAT_W-1:0]          q;
    logic                       load_hs, capture, release_hs, last_slot;

    // Round half up, then saturate to the feature range.
    if (SHIFT == 0) begin : g_q_pass
        assign q = s_data_i[FEAT_W-1:0];
    end else begin : g_q_round
        localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (SHIFT - 1);
        localparam logic [IN_W:0] QMAX = (IN_W + 1)'((1 << FEAT_W) - 1);
        logic [IN_W:0] t;
        assign t = ({1'b0, s_data_i} + HALF) >> SHIFT;
        assign q = (t > QMAX) ? {FEAT_W{1'b1}} : t[FEAT_W-1:0];
    end

    assign last_slot  = (cnt_q == LAST_IDX);
    assign load_hs    = (state_q == StLoad) && s_valid_i;
    assign capture    = (state_q == StSettle) && (scnt_q == '0);
    assign release_hs = (state_q == StOut) && m_ready_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scnt_d    = scnt_q;
        inp_d     = inp_q;
        m_valid_d = m_valid_q;
        m_class_d = m_class_q;
        s_ready_o = 1'b0;
        unique case (state_q)
            StLoad: begin
                s_ready_o = 1'b1;
                if (load_hs) begin
                    inp_d[cnt_q*FEAT_W +: FEAT_W] = q;
                    if (last_slot) begin
                        cnt_d   = '0;
                        scnt_d  = SCNT_W'(SETTLE_CYC);
                        state_d = StSettle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StSettle: begin
                if (capture) begin
                    m_class_d = mlp_out_i;
                    m_valid_d = 1'b1;
                    state_d   = StOut;
                end else begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
            StOut: begin
                if (release_hs) begin
                    m_valid_d = 1'b0;
                    state_d   = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StLoad;
            cnt_q     <= '0;
            scnt_q    <= '0;
            inp_q     <= '0;
            m_valid_q <= 1'b0;
            m_class_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scnt_q    <= scnt_d;
            inp_q     <= inp_d;
            m_valid_q <= m_valid_d;
            m_class_q <= m_class_d;
        end
    end

`ifdef LAST_CHECK_EN
    // Sticky framing error; the vector length stays fixed regardless of s_last.
    logic err_q, err_d, m_err_q, m_err_d;

    always_comb begin
        err_d   = err_q;
        m_err_d = m_err_q;
        if (load_hs && (s_last_i != last_slot)) err_d = 1'b1;
        if (capture) m_err_d = err_q;
        if (release_hs) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            m_err_q <= 1'b0;
        end else begin
            err_q   <= err_d;
            m_err_q <= m_err_d;
        end
    end

    assign m_err_o = m_err_q;
`else
    logic unused_last;
    assign unused_last = s_last_i;
    assign m_err_o     = 1'b0;
`endif

    assign mlp_inp_o = inp_q;
    assign m_valid_o = m_valid_q;
    assign m_class_o = m_class_q;

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// Directed + randomized bench for mlp_feature_sequencer against a sample-level reference model.
`timescale 1ns/1ps
module tb_mlp_feature_sequencer;

    localparam int unsigned N   = 8;
    localparam int unsigned IW  = 8;
    localparam int unsigned FW  = 4;
    localparam int unsigned CW  = 2;
    localparam int unsigned SET = 4;
    localparam int unsigned VW  = N * FW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [IW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic [VW-1:0] mlp_inp;
    logic [CW-1:0] mlp_out;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [CW-1:0] m_class;
    logic          m_err;

    int vectors = 0;
    int miscompares = 0;

    logic          tie_en = 1'b0;
    logic [CW-1:0] tie_val = '0;
    logic [VW-1:0] mvec = '0;
    logic [VW-1:0] saved_vec;
    logic [N*IW-1:0] dvec;

    mlp_feature_sequencer #(
        .N_FEAT(N), .IN_W(IW), .FEAT_W(FW), .CLASS_W(CW), .SETTLE_CYC(SET)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
        .mlp_inp_o(mlp_inp), .mlp_out_i(mlp_out),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_class_o(m_class), .m_err_o(m_err)
    );

    always #5 clk = ~clk;

    // Stand-in classifier core: sum of features modulo the class count.
    function automatic logic [CW-1:0] core_fn(input logic [VW-1:0] v);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(v[i*FW +: FW]);
        return CW'(s);
    endfunction

    assign mlp_out = tie_en ? tie_val : core_fn(mlp_inp);

    function automatic int quant(input int d);
        int s = IW - FW;
        int t;
        if (s == 0) return d;
        t = (d + (1 << (s - 1))) / (1 << s);
        return (t > (1 << FW) - 1) ? (1 << FW) - 1 : t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [IW-1:0] d, input logic l, input int gaps);
        repeat (gaps) tick();
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        chk("s_ready_load", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        s_data  = IW'($urandom);
        s_last  = 1'($urandom);
        mvec[idx*FW +: FW] = FW'(quant(int'(d)));
        chk("mlp_inp_slot", 64'(mlp_inp), 64'(mvec));
    endtask

    task automatic run_vec(input logic [N*IW-1:0] data, input logic [N-1:0] lasts,
                           input int gap_max, input int hold, input bit bp_valid);
        logic          exp_err = 1'b0;
        logic [CW-1:0] exp_cls;
        for (int i = 0; i < N; i++) begin
            send(i, data[i*IW +: IW], lasts[i], (gap_max > 0) ? $urandom_range(gap_max, 0) : 0);
`ifdef LAST_CHECK_EN
            if (lasts[i] != (i == N - 1)) exp_err = 1'b1;
`endif
        end
        exp_cls = tie_en ? tie_val : core_fn(mvec);
        if (bp_valid) begin
            s_valid = 1'b1;
            s_data  = IW'($urandom);
        end
        chk("m_valid_early", 64'(m_valid), 64'd0);
        repeat (SET) begin
            tick();
            chk("m_valid_settle", 64'(m_valid), 64'd0);
            chk("s_ready_settle", 64'(s_ready), 64'd0);
        end
        tick();
        chk("m_valid_rise", 64'(m_valid), 64'd1);
        chk("m_class", 64'(m_class), 64'(exp_cls));
        chk("m_err", 64'(m_err), 64'(exp_err));
        repeat (hold) begin
            tick();
            chk("m_valid_hold", 64'(m_valid), 64'd1);
            chk("m_class_hold", 64'(m_class), 64'(exp_cls));
            chk("s_ready_hold", 64'(s_ready), 64'd0);
            chk("mlp_inp_hold", 64'(mlp_inp), 64'(mvec));
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("m_valid_fall", 64'(m_valid), 64'd0);
        chk("s_ready_back", 64'(s_ready), 64'd1);
        chk("mlp_inp_after", 64'(mlp_inp), 64'(mvec));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_mlp_inp", 64'(mlp_inp), 64'd0);
        chk("rst_m_class", 64'(m_class), 64'd0);
        chk("rst_m_err", 64'(m_err), 64'd0);

        // Quantization corners with the core output tied.
        tie_en  = 1'b1;
        tie_val = 2'b10;
        run_vec(64'hF8F77F1817080700, 8'h80, 0, 0, 1'b0);
        chk("quant_pack", 64'(mlp_inp), 64'h00000000FF821100);
        tie_en = 1'b0;

        // Output backpressure with s_valid held high.
        dvec = {$urandom, $urandom};
        run_vec(dvec, 8'h80, 0, 10, 1'b1);

        // Reset mid-vector after three samples.
        for (int i = 0; i < 3; i++) send(i, IW'($urandom), 1'b0, 0);
        rst_n = 1'b0;
        #1;
        mvec = '0;
        chk("midrst_s_ready", 64'(s_ready), 64'd1);
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_mlp_inp", 64'(mlp_inp), 64'd0);
        tick();
        rst_n = 1'b1;
        run_vec({$urandom, $urandom}, 8'h80, 2, 1, 1'b0);

        // Same data with and without input bubbles.
        dvec = {$urandom, $urandom};
        run_vec(dvec, 8'h80, 0, 0, 1'b0);
        saved_vec = mvec;
        run_vec(dvec, 8'h80, 4, 0, 1'b0);
        chk("gap_equal", 64'(mlp_inp), 64'(saved_vec));

        // Early s_last, then correct framing.
        run_vec({$urandom, $urandom}, 8'h10, 0, 0, 1'b0);
        run_vec({$urandom, $urandom}, 8'h80, 0, 0, 1'b0);

        for (int v = 0; v < 12; v++) begin
            run_vec({$urandom, $urandom},
                    ($urandom_range(3, 0) == 0) ? N'($urandom) : N'(8'h80),
                    $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
